menu_overlay: RTL

//  Parametrised scrolling text-menu renderer for the HDMI path. Holds an N_ITEMS x ITEM_CHARS

---
 rtl/menu_overlay_if.sv | 23 ++
 rtl/menu_overlay.sv | 113 +++++++++++
 2 files changed

// File: rtl/menu_overlay_if.sv
// menu_overlay_if: pixel, font, button and buffer-write signals of the menu overlay
interface menu_overlay_if #(parameter int IW = 4, parameter int CW = 4);
  logic [9:0]    x, y;
  logic          btn_up, btn_down, btn_sel;
  logic [IW:0]   n_valid;
  logic          wr_en;
  logic [IW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [7:0]    wr_ch;
  logic [11:0]   font_addr;
  logic [7:0]    font_data;
  logic [23:0]   color;
  logic [IW-1:0] sel, top, chosen_index;
  logic          chosen_valid;
  modport master (
    output x, y, btn_up, btn_down, btn_sel, n_valid, wr_en, wr_row, wr_col, wr_ch, font_data,
    input  font_addr, color, sel, top, chosen_index, chosen_valid
  );
  modport slave (
    input  x, y, btn_up, btn_down, btn_sel, n_valid, wr_en, wr_row, wr_col, wr_ch, font_data,
    output font_addr, color, sel, top, chosen_index, chosen_valid
  );
endinterface

// File: rtl/menu_overlay.sv
// menu_overlay: scrolling text-menu renderer with title, highlighted selection and button navigation
module menu_overlay #(
  parameter int N_ITEMS = 16,
  parameter int ITEM_CHARS = 16,
  parameter int VIS_ROWS = 8,
  parameter int TITLE_LEN = 9,
  parameter logic [8*TITLE_LEN-1:0] TITLE = "Game Menu",
  parameter int TITLE_ROW = 5,
  parameter int TITLE_COL = 34,
  parameter int MENU_ROW = 8,
  parameter int MENU_COL = 32,
  parameter logic [23:0] FG = 24'hffffff,
  parameter logic [23:0] HL = 24'hffff00,
  parameter logic [23:0] BG = 24'h000000
) (
  input logic clk,
  input logic reset,
  menu_overlay_if.slave bus
);
  localparam int IW = $clog2(N_ITEMS);
  localparam int CW = $clog2(ITEM_CHARS);
  localparam logic [IW:0] VR = (IW+1)'(VIS_ROWS);
  logic [7:0] mem_q [N_ITEMS][ITEM_CHARS];
  logic [IW-1:0] sel_q, sel_d, top_q, top_d, chosen_index_q, chosen_index_d;
  logic chosen_valid_q, chosen_valid_d;
  logic [11:0] font_addr_q, font_addr_d;
  logic vis1_q, vis1_d, hl1_q, hl1_d, vis2_q, hl2_q;
  logic [2:0] bi1_q, bi1_d, bi2_q;
  logic [23:0] color_q, color_d;
  int c, r, it, ti;
  logic in_title, in_item;
  logic [7:0] ch;
  logic [IW:0] n, s, t, tmax, ns, nt;
  always_ff @(posedge clk) if (bus.wr_en) mem_q[bus.wr_row][bus.wr_col] <= bus.wr_ch;
  // Stage 1: cell decode and character lookup; buffer read is combinational so a same-cycle write shows the old char
  always_comb begin
    c = int'(bus.x[9:3]);
    r = int'(bus.y[9:4]);
    ti = c - TITLE_COL;
    it = int'(top_q) + r - MENU_ROW;
    in_title = r == TITLE_ROW && ti >= 0 && ti < TITLE_LEN;
    in_item = r >= MENU_ROW && r < MENU_ROW + VIS_ROWS && c >= MENU_COL && c < MENU_COL + ITEM_CHARS;
    ch = in_title ? TITLE[8*(TITLE_LEN-1-ti) +: 8] : mem_q[IW'(it)][CW'(c - MENU_COL)];
    vis1_d = in_title || (in_item && it < int'(bus.n_valid));
    font_addr_d = vis1_d ? {ch, bus.y[3:0]} : '0;
    hl1_d = in_item && it == int'(sel_q);
    bi1_d = 3'd7 - bus.x[2:0];
    color_d = vis2_q && bus.font_data[bi2_q] ? (hl2_q ? HL : FG) : BG;
  end
  always_comb begin
    n = bus.n_valid;
    s = {1'b0, sel_q};
    t = {1'b0, top_q};
    tmax = n > VR ? n - VR : '0;
    ns = s;
    nt = t;
    chosen_valid_d = 1'b0;
    if (n == '0) begin
      ns = '0;
      nt = '0;
    end else if (n <= s) begin
      ns = n - 1'b1;
      nt = tmax;
    end else begin
      chosen_valid_d = bus.btn_sel;
      if (bus.btn_down && !bus.btn_up) begin
        ns = s == n - 1'b1 ? '0 : s + 1'b1;
        nt = s == n - 1'b1 ? '0 : (s + 1'b1 >= t + VR ? s + 1'b1 + 1'b1 - VR : t);
      end else if (bus.btn_up && !bus.btn_down) begin
        ns = s == '0 ? n - 1'b1 : s - 1'b1;
        nt = s == '0 ? tmax : (s - 1'b1 < t ? s - 1'b1 : t);
      end
    end
    sel_d = ns[IW-1:0];
    top_d = nt[IW-1:0];
    chosen_index_d = chosen_valid_d ? sel_q : chosen_index_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q <= '0;
      top_q <= '0;
      chosen_valid_q <= 1'b0;
      chosen_index_q <= '0;
      font_addr_q <= '0;
      vis1_q <= 1'b0;
      hl1_q <= 1'b0;
      bi1_q <= '0;
      vis2_q <= 1'b0;
      hl2_q <= 1'b0;
      bi2_q <= '0;
      color_q <= BG;
    end else begin
      sel_q <= sel_d;
      top_q <= top_d;
      chosen_valid_q <= chosen_valid_d;
      chosen_index_q <= chosen_index_d;
      font_addr_q <= font_addr_d;
      vis1_q <= vis1_d;
      hl1_q <= hl1_d;
      bi1_q <= bi1_d;
      vis2_q <= vis1_q;
      hl2_q <= hl1_q;
      bi2_q <= bi1_q;
      color_q <= color_d;
    end
  end
  assign bus.font_addr = font_addr_q;
  assign bus.color = color_q;
  assign bus.sel = sel_q;
  assign bus.top = top_q;
  assign bus.chosen_valid = chosen_valid_q;
  assign bus.chosen_index = chosen_index_q;
endmodule
